// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues one sequential request at a time to a
// variable-latency memory and buffers tagged responses in a DEPTH-entry FIFO.
module fetch_queue #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    INSTR_WIDTH = 16,
  parameter int                    DEPTH       = 4,
  parameter int                    PC_INCR     = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [3:0]            HLT_OPCODE  = 4'hF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect_valid,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc,
  output logic                         imem_req,
  output logic [ADDR_WIDTH-1:0]        imem_addr,
  input  logic                         imem_rvalid,
  input  logic [INSTR_WIDTH-1:0]       imem_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTR_WIDTH-1:0]       out_instr,
  output logic [ADDR_WIDTH-1:0]        out_pc,
  output logic [ADDR_WIDTH-1:0]        out_pc_next,
  output logic [ADDR_WIDTH-1:0]        fetch_pc,
  output logic                         fetch_halted,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int                    CW   = $clog2(DEPTH + 1);
  localparam int                    PW   = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] INCR = ADDR_WIDTH'(PC_INCR);
  localparam logic [CW-1:0]         FULL = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0]  req_pc_q, req_pc_d;
  logic                   outstanding_q, outstanding_d;
  logic                   discard_q, discard_d;
  logic                   halted_q, halted_d;
  logic [CW-1:0]          count_q, count_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_mem_q    [DEPTH];

  logic issue, enq, deq, is_hlt;

  // Output handshake: a word transfers on a clock edge where out_valid and
  // out_ready are both high; out_valid never depends on out_ready.
  assign out_valid   = (count_q != '0);
  assign deq         = out_valid & out_ready;
  assign issue       = ~rst & ~redirect_valid & ~halted_q & ~outstanding_q & (count_q < FULL);
  assign enq         = imem_rvalid & ~discard_q & ~redirect_valid;
  assign is_hlt      = (imem_rdata[INSTR_WIDTH-1 -: 4] == HLT_OPCODE);

  assign imem_req     = issue;
  assign imem_addr    = fetch_pc_q;
  assign fetch_pc     = fetch_pc_q;
  assign fetch_halted = halted_q;
  assign count        = count_q;
  assign out_instr    = instr_mem_q[rd_ptr_q];
  assign out_pc       = pc_mem_q[rd_ptr_q];
  assign out_pc_next  = pc_mem_q[rd_ptr_q] + INCR;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    halted_d      = halted_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    if (redirect_valid) begin
      // A request still in flight must have its eventual response dropped.
      fetch_pc_d    = redirect_pc;
      halted_d      = 1'b0;
      outstanding_d = outstanding_q & ~imem_rvalid;
      discard_d     = outstanding_q & ~imem_rvalid;
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
    end else begin
      if (imem_rvalid) begin
        outstanding_d = 1'b0;
        discard_d     = 1'b0;
      end
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + INCR;
        req_pc_d      = fetch_pc_q;
        outstanding_d = 1'b1;
      end
      if (enq) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        if (is_hlt) halted_d = 1'b1;
      end
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      halted_q      <= 1'b0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      halted_q      <= halted_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Storage is cleared so the head fields are never X on an empty FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (enq) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
    end
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end; successor to the single-word IF stage.
- Decouples PC generation from the IF/ID register.
- Issues sequential requests to a variable-latency instruction memory and buffers returned words in a DEPTH-entry FIFO, each tagged with its PC and PC+increment.
- Supports redirect from branch resolution, halt detection, and discard of stale in-flight responses.

Parameters:
ADDR_WIDTH, 16, PC and memory address width
INSTR_WIDTH, 16, instruction word width
DEPTH, 4, FIFO entries; power of two, >= 2
PC_INCR, 2, bytes added to PC per fetched instruction
RESET_PC, 0, fetch PC after reset
HLT_OPCODE, 4'hF, value of instr[INSTR_WIDTH-1 -: 4] that stops fetching

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
redirect_valid  in  1  branch/jump resolved; restart fetch at redirect_pc
redirect_pc  in  ADDR_WIDTH  new fetch address
imem_req  out  1  request strobe; memory always accepts in the same cycle
imem_addr  out  ADDR_WIDTH  request address (= fetch_pc)
imem_rvalid  in  1  response valid; at least 1 cycle after its request
imem_rdata  in  INSTR_WIDTH  response word
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head (IF/ID not stalled)
out_instr  out  INSTR_WIDTH  head instruction
out_pc  out  ADDR_WIDTH  head instruction address
out_pc_next  out  ADDR_WIDTH  out_pc + PC_INCR, mod 2^ADDR_WIDTH
fetch_pc  out  ADDR_WIDTH  next address to request
fetch_halted  out  1  HLT word enqueued; fetching stopped
count  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at a clk edge):
  - fetch_pc = RESET_PC; FIFO empty (count=0, out_valid=0).
  - outstanding=0, discard=0, fetch_halted=0.
  - rst overrides every other input in that cycle.
- Outstanding requests: at most one in flight.
  - outstanding sets on issue and clears on imem_rvalid.
  - discard marks an in-flight request whose response must be dropped.
- Issue (combinational):
  - imem_req = ~rst & ~redirect_valid & ~fetch_halted & ~outstanding & (count < DEPTH).
  - imem_addr = fetch_pc.
  - On issue: fetch_pc += PC_INCR, wrapping mod 2^ADDR_WIDTH.
  - The request PC is held in a register for tagging the response.
- Response handling, imem_rvalid=1:
  - discard=1 or redirect_valid=1 in the same cycle: word dropped, discard cleared.
  - Otherwise: enqueue {rdata, tagged PC} at the tail.
  - Space is guaranteed by the issue rule; enqueue never overflows.
- Halt: if an enqueued word's top 4 bits equal HLT_OPCODE, fetch_halted=1 from the next cycle and no further requests issue. The HLT word itself is enqueued and delivered normally.
- Dequeue: transfer when out_valid & out_ready.
  - Head fields are driven directly from FIFO storage: zero-latency, no bubble.
  - Simultaneous enqueue and dequeue leaves count unchanged, including when count=DEPTH.
- Redirect, redirect_valid=1 at edge t:
  - FIFO flushed: count=0 and pointers reset at t+1.
  - fetch_pc = redirect_pc; fetch_halted cleared.
  - If a request is outstanding with no rvalid this cycle: discard=1.
  - A dequeue handshake in the same cycle still counts as delivered. The consumer owns that word; its flush is the consumer's responsibility.
  - No request issues in the redirect cycle.
- Redirect latency, 1-cycle memory, nothing in flight:
  - imem_req with addr=redirect_pc at t+1.
  - rvalid at t+2.
  - out_valid with out_pc=redirect_pc at t+3.
- Redirect with a stale request in flight: the first issue waits until the cycle after the stale rvalid.
- Back-to-back redirects: the last one wins; discard stays set until one rvalid arrives.
- Empty FIFO: out_instr, out_pc and out_pc_next are don't-care, but must not be X after reset (storage reset to 0).
- Throughput: one instruction per 2 cycles with 1-cycle memory (single outstanding request). Adding a second outstanding request is out of scope.

Test Plan:
- Reset then run, memory latency 1, words 0x0000..0x0003 at 0x0000/2/4/6, out_ready=1: out_pc sequence 0x0000, 0x0002, 0x0004 with matching instr; first out_valid 3 cycles after rst deasserts; imem_req never while outstanding.
- Backpressure, out_ready=0, DEPTH=4: count saturates at 4, imem_req stays 0, no overflow. Raise out_ready for 1 cycle: count drops to 3, one new request issues next cycle. Order is preserved.
- Redirect with in-flight request, latency 3: redirect_pc=0x0040 one cycle after issue to 0x0006. The 0x0006 response is dropped; the next request addr is 0x0040, issued the cycle after the stale rvalid. FIFO is empty after redirect; first out_pc=0x0040.
- HLT: word 0xF000 at 0x0008. It is delivered with out_pc=0x0008, fetch_halted=1, and no request for 0x000A. A redirect to 0x0010 clears fetch_halted and resumes fetch at 0x0010.
- Simultaneous events:
  - redirect + rvalid + dequeue in one cycle: response dropped, dequeued word counted, count=0 after, discard=0.
  - rst asserted mid-stream with count=3: all state at reset values next cycle, fetch_pc=RESET_PC.
- Wrap-around: redirect_pc=0xFFFE. out_pc=0xFFFE with out_pc_next=0x0000; the next request addr is 0x0000.
